// File: rtl/frogger_game_seq_if.sv
`default_nettype none
// =============================================================================
// Module      : frogger_game_seq_if
// Description : Event inputs and status outputs of the Frogger phase sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
interface frogger_game_seq_if;
    logic       i_Start;
    logic       i_Collided;
    logic       i_Frog_Home;
    logic       o_Game_Active;
    logic       o_Frog_Reset;
    logic [2:0] o_State;
    logic [1:0] o_Lives;
    logic [3:0] o_Level;
    logic [5:0] o_Timer;

    modport master (
        output i_Start, i_Collided, i_Frog_Home,
        input  o_Game_Active, o_Frog_Reset, o_State, o_Lives, o_Level, o_Timer
    );

    modport slave (
        input  i_Start, i_Collided, i_Frog_Home,
        output o_Game_Active, o_Frog_Reset, o_State, o_Lives, o_Level, o_Timer
    );
endinterface
`default_nettype wire

// File: rtl/frogger_game_seq.sv
`default_nettype none
// =============================================================================
// Module      : frogger_game_seq
// Description : Game-phase sequencer (lives, level, round timer, phase FSM).
//               FROGGER_BONUS_LIFE_EN: grant a life on every level-up.
// Revision    : 1.0 - initial release
// =============================================================================
module frogger_game_seq #(
    parameter int CLKS_PER_SEC    = 25000000,
    parameter int START_LIVES     = 3,
    parameter int ROUND_SECONDS   = 30,
    parameter int DEATH_SECONDS   = 1,
    parameter int LEVEL_SECONDS   = 2,
    parameter int HOMES_PER_LEVEL = 5
) (
    input  wire logic          i_Clk,
    input  wire logic          i_Rst_L,
    frogger_game_seq_if.slave  game
);

    localparam int c_PRE_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX   = c_PRE_W'(CLKS_PER_SEC - 1);
    localparam logic [1:0]         c_LIVES     = 2'(START_LIVES);
    localparam logic [5:0]         c_ROUND     = 6'(ROUND_SECONDS);
    localparam logic [2:0]         c_HOMES     = 3'(HOMES_PER_LEVEL);
    localparam logic [7:0]         c_DEATH_END = 8'(DEATH_SECONDS - 1);
    localparam logic [7:0]         c_LEVEL_END = 8'(LEVEL_SECONDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t               r_state,      w_next_state;
    logic [c_PRE_W-1:0]   r_prescaler,  w_prescaler_next;
    logic [1:0]           r_lives,      w_lives_next;
    logic [3:0]           r_level,      w_level_next;
    logic [5:0]           r_timer,      w_timer_next;
    logic [2:0]           r_homes,      w_homes_next;
    logic [7:0]           r_hold,       w_hold_next;
    logic                 r_frog_reset, w_frog_reset_next;
    logic                 r_start_prev;
    logic                 w_start_edge;
    logic                 w_tick;
    logic                 w_play_entry;

    assign w_start_edge = game.i_Start & ~r_start_prev;
    assign w_tick       = (r_prescaler == c_PRE_MAX);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state      <= ST_IDLE;
            r_prescaler  <= '0;
            r_lives      <= '0;
            r_level      <= '0;
            r_timer      <= '0;
            r_homes      <= '0;
            r_hold       <= '0;
            r_frog_reset <= 1'b0;
            r_start_prev <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_prescaler  <= w_prescaler_next;
            r_lives      <= w_lives_next;
            r_level      <= w_level_next;
            r_timer      <= w_timer_next;
            r_homes      <= w_homes_next;
            r_hold       <= w_hold_next;
            r_frog_reset <= w_frog_reset_next;
            r_start_prev <= game.i_Start;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_prescaler_next  = '0;
        w_lives_next      = r_lives;
        w_level_next      = r_level;
        w_timer_next      = r_timer;
        w_homes_next      = r_homes;
        w_hold_next       = r_hold;
        w_frog_reset_next = 1'b0;
        w_play_entry      = 1'b0;

        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (w_start_edge) begin
                    w_next_state = ST_PLAY;
                    w_lives_next = c_LIVES;
                    w_level_next = 4'd1;
                    w_homes_next = 3'd0;
                    w_play_entry = 1'b1;
                end
            end
            ST_PLAY: begin
                w_prescaler_next = w_tick ? '0 : r_prescaler + 1'b1;
                // Timeout is indistinguishable from a collision.
                if (game.i_Collided || (w_tick && r_timer == 6'd0)) begin
                    w_next_state = ST_DYING;
                    w_lives_next = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
                end else if (game.i_Frog_Home) begin
                    if (r_homes + 3'd1 == c_HOMES) begin
                        w_next_state = ST_LEVEL_UP;
                        w_homes_next = 3'd0;
                        w_level_next = (r_level == 4'd15) ? 4'd15 : r_level + 4'd1;
`ifdef FROGGER_BONUS_LIFE_EN
                        w_lives_next = (r_lives == 2'd3) ? 2'd3 : r_lives + 2'd1;
`endif
                    end else begin
                        w_homes_next = r_homes + 3'd1;
                        w_play_entry = 1'b1;
                    end
                end else if (w_tick) begin
                    w_timer_next = r_timer - 6'd1;
                end
            end
            ST_DYING: begin
                w_prescaler_next = w_tick ? '0 : r_prescaler + 1'b1;
                if (w_tick) begin
                    if (r_hold == c_DEATH_END) begin
                        if (r_lives == 2'd0) begin
                            w_next_state = ST_GAME_OVER;
                        end else begin
                            w_next_state = ST_PLAY;
                            w_play_entry = 1'b1;
                        end
                    end else begin
                        w_hold_next = r_hold + 8'd1;
                    end
                end
            end
            ST_LEVEL_UP: begin
                w_prescaler_next = w_tick ? '0 : r_prescaler + 1'b1;
                if (w_tick) begin
                    if (r_hold == c_LEVEL_END) begin
                        w_next_state = ST_PLAY;
                        w_play_entry = 1'b1;
                    end else begin
                        w_hold_next = r_hold + 8'd1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase

        if (w_play_entry) begin
            w_timer_next      = c_ROUND;
            w_prescaler_next  = '0;
            w_frog_reset_next = 1'b1;
        end
        // Second counting restarts from zero in every new phase.
        if (w_next_state != r_state) begin
            w_prescaler_next = '0;
            w_hold_next      = 8'd0;
        end
    end

    assign game.o_Game_Active = (r_state == ST_PLAY);
    assign game.o_Frog_Reset  = r_frog_reset;
    assign game.o_State       = r_state;
    assign game.o_Lives       = r_lives;
    assign game.o_Level       = r_level;
    assign game.o_Timer       = r_timer;

endmodule
`default_nettype wire
